register_piso: RTL and testbench
================================

Name: register_piso

Overview:
- Parallel-in/serial-out shift register: the transmit-side counterpart of our serial-in 4-bit register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per clock on s_out, with frame qualifiers s_valid and last.
- Drives the serial-in register's d_in directly, so a word can loop back through the pair.

Parameters:
- WIDTH, 4, bits per word (legal range 2..16).
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  p_in holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- p_in  input  WIDTH  parallel word.
- s_out  output  1  serial data bit.
- s_valid  output  1  s_out carries a frame bit.
- last  output  1  current s_out bit is the final bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset low asynchronously forces state = IDLE, shift register = 0, bit counter = 0.
  - During reset: s_out = 0, s_valid = 0, last = 0, busy = 0, load_ready = 0.
  - load_ready goes high on the first rising clk edge after reset is released.
- Handshake:
  - A load occurs on a rising edge where load_valid & load_ready are both 1.
  - p_in is sampled only on that edge.
  - load_valid while load_ready = 0 is ignored; the word is not queued.
- FSM states:
  - IDLE: load_ready = 1, s_valid = 0, busy = 0, s_out = 0. A load moves the FSM to SHIFT.
  - SHIFT: s_valid = 1 and busy = 1. s_out is the current head bit of the shift register.
    - The counter increments each cycle.
    - After the WIDTH-th bit: go to IDLE, or PARITY when the optional feature is enabled.
- Latency and ordering:
  - The first bit appears on s_out in the cycle after the load edge.
  - s_out is registered; no combinational path from p_in to s_out.
  - Bit k of the frame is on s_out during cycle k+1 after the load edge, for k = 0..WIDTH-1.
  - MSB_FIRST selects the bit order.
  - last = 1 only during the final frame bit.
- Back-to-back loads:
  - load_ready is also 1 during the cycle where last = 1.
  - A load in that cycle starts the next frame immediately: s_valid stays high with no gap.
  - The counter resets to 0 and the FSM stays in SHIFT.
  - Without a load in that cycle, the FSM returns to IDLE.
- Counter:
  - Width is clog2(WIDTH+1).
  - It never wraps past WIDTH; reaching the terminal count always ends the frame.
- Reset mid-frame:
  - The frame is aborted immediately; no partial bits are emitted after reset releases.
  - The block restarts in IDLE.
- Simultaneous events: reset has priority over load and shift.

Optional Feature:
- Macro: REGISTER_PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the loaded word) is appended as bit WIDTH of the frame, in state PARITY.
  - s_valid = 1 for that bit.
  - last moves from the final data bit to the parity bit.
  - Frame length becomes WIDTH+1 cycles.
  - The back-to-back load window moves to the parity cycle.
- Undefined: the PARITY state and parity logic are absent; frame length is WIDTH cycles.

Test Plan:
- Reset then basic frame:
  - Stimulus: reset low 10 ns, then high; load 4'b1011 with MSB_FIRST=1.
  - Response: s_out = 1,0,1,1 on the 4 cycles after the load edge; s_valid = 1 for exactly 4 cycles; last = 1 on the 4th bit; then idle with s_out = 0.
- Busy rejection:
  - Stimulus: during the frame above, pulse load_valid with p_in = 4'b0110 in cycle 2.
  - Response: load_ready = 0 in cycle 2; the word is ignored; the output sequence is unchanged.
- Back-to-back:
  - Stimulus: load 4'b1100, then hold load_valid with 4'b0011 during the last cycle.
  - Response: 8 contiguous s_valid cycles carrying 1,1,0,0,0,0,1,1; last pulses on cycles 4 and 8.
- Reset mid-frame:
  - Stimulus: assert reset after the 2nd bit of 4'b1111.
  - Response: all outputs go to 0 asynchronously; after release, s_valid = 0 until a new load.
- LSB-first loopback:
  - Stimulus: MSB_FIRST=0; load 4'b0001; drive the serial-in 4-bit register with s_out.
  - Response: s_out = 1,0,0,0; after 4 shifts the serial-in register output matches the expected shifted word.
- Parity build:
  - Stimulus: REGISTER_PISO_PARITY_EN defined; load 4'b1011.
  - Response: s_out = 1,0,1,1,1 (parity = 1); last only on the 5th bit; 4'b1001 yields parity bit 0.

Source files
------------

// File: rtl/register_piso.sv
// -----------------------------------------------------------------------------
// register_piso
//
// Parallel-in / serial-out shift register. It is the transmit-side partner of the
// serial-in 4-bit register. A WIDTH-bit word is accepted through a valid/ready
// handshake and then shifted out one bit per clock. s_valid and last qualify each
// bit of the frame. s_out can drive the serial-in register's d_in directly.
//
// Parameters
//   WIDTH      bits per word (2..16)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   load_valid  p_in holds a word to send
//   load_ready  a word can be accepted this cycle
//   p_in        parallel word, sampled only on the load edge
//   s_out       serial data bit (0 when idle)
//   s_valid     s_out carries a frame bit
//   last        s_out carries the final bit of the frame
//   busy        a frame is in progress
//
// Optional feature
//   REGISTER_PISO_PARITY_EN: when defined, an even-parity bit (XOR of the loaded
//   word) follows the data bits in state StParity. last and the back-to-back load
//   window move to that bit, so a frame is WIDTH+1 cycles long.
// -----------------------------------------------------------------------------
module register_piso #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] p_in,
    output logic             s_out,
    output logic             s_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef REGISTER_PISO_PARITY_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Holds load_ready low until the first clock edge after reset is released.
    logic              armed_q;
`ifdef REGISTER_PISO_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic load_fire;
    logic data_end;
    logic head_bit;

    assign load_fire = load_valid & load_ready;
    // Final data bit of the frame is on s_out this cycle.
    assign data_end  = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));
    assign head_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_fire) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (data_end) begin
`ifdef REGISTER_PISO_PARITY_EN
                    state_d = StParity;
`else
                    // A load on the final bit chains the next frame with no gap.
                    state_d = load_fire ? StShift : StIdle;
`endif
                end
            end
`ifdef REGISTER_PISO_PARITY_EN
            StParity: begin
                state_d = load_fire ? StShift : StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        load_ready = 1'b0;
        s_out      = 1'b0;
        s_valid    = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        unique case (state_q)
            StIdle: begin
                load_ready = armed_q;
            end
            StShift: begin
                s_out   = head_bit;
                s_valid = 1'b1;
                busy    = 1'b1;
`ifndef REGISTER_PISO_PARITY_EN
                last       = data_end;
                load_ready = data_end;
`endif
            end
`ifdef REGISTER_PISO_PARITY_EN
            StParity: begin
                s_out      = parity_q;
                s_valid    = 1'b1;
                busy       = 1'b1;
                last       = 1'b1;
                load_ready = 1'b1;
            end
`endif
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, bit counter, parity
    // -------------------------------------------------------------------------
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_fire) begin
            shreg_d = p_in;
            cnt_d   = '0;
        end else if (state_q == StShift) begin
            // Move the next bit into the head position.
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            // Terminal count always ends the frame, so the counter never wraps.
            cnt_d   = data_end ? '0 : cnt_q + CntW'(1);
        end
    end

`ifdef REGISTER_PISO_PARITY_EN
    always_comb begin
        parity_d = parity_q;
        if (load_fire) begin
            parity_d = ^p_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

`ifdef REGISTER_PISO_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_register_piso.sv
`timescale 1ns/1ps
module tb_register_piso;

    localparam int W = 4;
`ifdef REGISTER_PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] p_in = '0;

    logic lr_m, so_m, sv_m, last_m, busy_m;
    logic lr_l, so_l, sv_l, last_l, busy_l;

    // Packed view of outputs: {s_out, s_valid, last, busy, load_ready}
    logic [4:0] out_m, out_l;
    assign out_m = {so_m, sv_m, last_m, busy_m, lr_m};
    assign out_l = {so_l, sv_l, last_l, busy_l, lr_l};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    register_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (lr_m),
        .p_in       (p_in),
        .s_out      (so_m),
        .s_valid    (sv_m),
        .last       (last_m),
        .busy       (busy_m)
    );

    register_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (lr_l),
        .p_in       (p_in),
        .s_out      (so_l),
        .s_valid    (sv_l),
        .last       (last_l),
        .busy       (busy_l)
    );

    // Reference: bit k of the frame for word w. Index W is the even-parity bit.
    function automatic logic model_bit(input logic [W-1:0] w, input int k, input bit msb);
        if (k >= W) return ^w;
        return msb ? w[W-1-k] : w[k];
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        load_valid = 1'b0;
        #3;
        vectors++;
        if (out_m !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_hold_m: got %b expected %b", out_m, 5'b00000);
        end
        #5;  // a rising edge has passed while in reset
        vectors++;
        if (out_l !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_edge_l: got %b expected %b", out_l, 5'b00000);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (out_m !== 5'b00000) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b expected %b", out_m, 5'b00000);
        end
        @(negedge clk);
        vectors++;
        if (out_m !== 5'b00001) begin
            miscompares++;
            $display("FAIL ready_after_edge: got %b expected %b", out_m, 5'b00001);
        end
    endtask

    // Basic frame with a rejected load attempt in cycle 2.
    task automatic test_basic();
        logic [W-1:0] w;
        logic [4:0]   e;
        w = 4'b1011;
        @(negedge clk);
        load_valid = 1'b1;
        p_in = w;
        vectors++;
        if (lr_m !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready: got %b expected %b", lr_m, 1'b1);
        end
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (k == 1) begin
                load_valid = 1'b1;
                p_in = 4'b0110;
            end
            e = {model_bit(w, k, 1'b1), 1'b1, (k == FL - 1), 1'b1, (k == FL - 1)};
            vectors++;
            if (out_m !== e) begin
                miscompares++;
                $display("FAIL basic_bit%0d: got %b expected %b", k, out_m, e);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_m !== 5'b00001) begin
            miscompares++;
            $display("FAIL basic_idle: got %b expected %b", out_m, 5'b00001);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2, wk;
        logic [4:0]   e;
        int           kk;
        w1 = 4'b1100;
        w2 = 4'b0011;
        @(negedge clk);
        load_valid = 1'b1;
        p_in = w1;
        for (int k = 0; k < 2 * FL; k++) begin
            @(negedge clk);
            kk = k % FL;
            wk = (k < FL) ? w1 : w2;
            load_valid = (k == FL - 1);
            p_in = w2;
            e = {model_bit(wk, kk, 1'b1), 1'b1, (kk == FL - 1), 1'b1, (kk == FL - 1)};
            vectors++;
            if (out_m !== e) begin
                miscompares++;
                $display("FAIL b2b_bit%0d: got %b expected %b", k, out_m, e);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_m !== 5'b00001) begin
            miscompares++;
            $display("FAIL b2b_idle: got %b expected %b", out_m, 5'b00001);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        load_valid = 1'b1;
        p_in = 4'b1111;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (sv_m !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_active: got %b expected %b", sv_m, 1'b1);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({out_m, out_l} !== 10'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got %b expected %b", {out_m, out_l}, 10'b0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_m !== 5'b00000) begin
            miscompares++;
            $display("FAIL midrst_hold: got %b expected %b", out_m, 5'b00000);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (out_m !== 5'b00000) begin
            miscompares++;
            $display("FAIL midrst_release: got %b expected %b", out_m, 5'b00000);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (out_m !== 5'b00001) begin
                miscompares++;
                $display("FAIL midrst_idle%0d: got %b expected %b", c, out_m, 5'b00001);
            end
        end
    endtask

    // LSB-first word looped into a serial-in register that shifts in at bit 0.
    task automatic test_lsb_loopback();
        logic [W-1:0] w, sipo, rev;
        logic [4:0]   e;
        w = 4'b0001;
        sipo = '0;
        for (int i = 0; i < W; i++) rev[i] = w[W-1-i];
        @(negedge clk);
        load_valid = 1'b1;
        p_in = w;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = {model_bit(w, k, 1'b0), 1'b1, (k == FL - 1), 1'b1, (k == FL - 1)};
            vectors++;
            if (out_l !== e) begin
                miscompares++;
                $display("FAIL lsb_bit%0d: got %b expected %b", k, out_l, e);
            end
            if (k < W) sipo = {sipo[W-2:0], so_l};
        end
        vectors++;
        if (sipo !== rev) begin
            miscompares++;
            $display("FAIL loopback_word: got %b expected %b", sipo, rev);
        end
        @(negedge clk);
        vectors++;
        if (out_l !== 5'b00001) begin
            miscompares++;
            $display("FAIL lsb_idle: got %b expected %b", out_l, 5'b00001);
        end
    endtask

`ifdef REGISTER_PISO_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] w;
        logic [4:0]   e;
        w = 4'b1001;
        @(negedge clk);
        load_valid = 1'b1;
        p_in = w;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = {model_bit(w, k, 1'b1), 1'b1, (k == W), 1'b1, (k == W)};
            vectors++;
            if (out_m !== e) begin
                miscompares++;
                $display("FAIL parity_bit%0d: got %b expected %b", k, out_m, e);
            end
        end
        @(negedge clk);
        vectors++;
        if (out_m !== 5'b00001) begin
            miscompares++;
            $display("FAIL parity_idle: got %b expected %b", out_m, 5'b00001);
        end
    endtask
`endif

    // Random loads checked against a queue of expected frame bits per DUT.
    task automatic test_random();
        logic       qm[$];
        logic       ql[$];
        logic [4:0] em, el;
        logic       rdy;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            em = (qm.size() == 0) ? 5'b00001 :
                 {qm[0], 1'b1, (qm.size() == 1), 1'b1, (qm.size() == 1)};
            el = (ql.size() == 0) ? 5'b00001 :
                 {ql[0], 1'b1, (ql.size() == 1), 1'b1, (ql.size() == 1)};
            vectors++;
            if (out_m !== em) begin
                miscompares++;
                $display("FAIL rand_msb_c%0d: got %b expected %b", c, out_m, em);
            end
            vectors++;
            if (out_l !== el) begin
                miscompares++;
                $display("FAIL rand_lsb_c%0d: got %b expected %b", c, out_l, el);
            end
            rdy = (qm.size() <= 1);
            load_valid = ($urandom_range(0, 2) == 0);
            p_in = W'($urandom());
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (load_valid && rdy) begin
                for (int k = 0; k < FL; k++) begin
                    qm.push_back(model_bit(p_in, k, 1'b1));
                    ql.push_back(model_bit(p_in, k, 1'b0));
                end
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        repeat (FL + 1) @(negedge clk);
        vectors++;
        if (out_m !== 5'b00001) begin
            miscompares++;
            $display("FAIL rand_drain: got %b expected %b", out_m, 5'b00001);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_frame();
        test_lsb_loopback();
`ifdef REGISTER_PISO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
